// File: rtl/load_store_unit.sv
// load_store_unit
//   Accepts one load/store request at a time from the execute stage, checks
//   it for illegal encodings, misalignment and out-of-range addresses, issues
//   legal accesses to the data memory for one cycle, collects load data and
//   returns a single response to writeback.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_load/store      access kind
//   req_base/offset     base register and signed 12-bit immediate
//   req_wdata           store data
//   req_funct3          RV32I size/sign code
//   req_rd              destination register tag
//   mem_addr/offset     base and offset presented to the data memory
//   mem_value           store data to the memory
//   mem_funct3          access code to the memory
//   mem_read/write      one-cycle memory strobes
//   mem_data            read data, valid the cycle after mem_read
//   resp_valid/ready    response handshake
//   resp_rd             destination tag of the response
//   resp_data           load result (0 for stores and faults)
//   resp_is_load        response belongs to a load
//   resp_misaligned     misaligned access flag
//   resp_fault          illegal encoding or address range fault flag
module load_store_unit #(
    parameter int unsigned MEMSIZE = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [31:0] req_base,
    input  logic [11:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    output logic [31:0] mem_addr,
    output logic [11:0] mem_offset,
    output logic [31:0] mem_value,
    output logic [2:0]  mem_funct3,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_is_load,
    output logic        resp_misaligned,
    output logic        resp_fault
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA, RESP} state_t;

    state_t      state;

    logic [31:0] ea;
    logic [2:0]  size;
    logic [32:0] ea_end;
    logic        illegal;
    logic        misaligned;
    logic        range_fault;

    // Request checks are evaluated on the live request fields so the
    // fault decision is taken at the accepting edge.
    always_comb begin
        ea = req_base + {{20{req_offset[11]}}, req_offset};
        case (req_funct3[1:0])
            2'd0:    size = 3'd1;
            2'd1:    size = 3'd2;
            default: size = 3'd4;
        endcase
        // 33-bit end address so a wrap past 2^32 still reads as out of range
        ea_end      = {1'b0, ea} + {30'd0, size};
        illegal     = (req_load == req_store)
                   || (req_load  && (req_funct3 == 3'd3 || req_funct3 >= 3'd6))
                   || (req_store && (req_funct3 > 3'd2));
        misaligned  = ((size == 3'd2) && ea[0])
                   || ((size == 3'd4) && (ea[1:0] != 2'b00));
        range_fault = ea_end > 33'(MEMSIZE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            req_ready       <= 1'b1;
            mem_addr        <= '0;
            mem_offset      <= '0;
            mem_value       <= '0;
            mem_funct3      <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rd         <= '0;
            resp_data       <= '0;
            resp_is_load    <= 1'b0;
            resp_misaligned <= 1'b0;
            resp_fault      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready    <= 1'b0;
                        resp_rd      <= req_rd;
                        resp_is_load <= req_load;
                        resp_data    <= '0;
                        if (misaligned || illegal || range_fault) begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_misaligned <= misaligned;
                            resp_fault      <= illegal || range_fault;
                        end else begin
                            state           <= ISSUE;
                            resp_misaligned <= 1'b0;
                            resp_fault      <= 1'b0;
                            mem_addr        <= req_base;
                            mem_offset      <= req_offset;
                            mem_value       <= req_wdata;
                            mem_funct3      <= req_funct3;
                            mem_read        <= req_load;
                            mem_write       <= req_store;
                        end
                    end
                end
                ISSUE: begin
                    state      <= DATA;
                    mem_addr   <= '0;
                    mem_offset <= '0;
                    mem_value  <= '0;
                    mem_funct3 <= '0;
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                end
                DATA: begin
                    // memory already sign/zero extended the read data
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_data  <= resp_is_load ? mem_data : '0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state           <= IDLE;
                        req_ready       <= 1'b1;
                        resp_valid      <= 1'b0;
                        resp_rd         <= '0;
                        resp_data       <= '0;
                        resp_is_load    <= 1'b0;
                        resp_misaligned <= 1'b0;
                        resp_fault      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
